// File: rtl/aes_round_ctrl_param_if.sv
// Handshake and status bundle between the AES round sequencer and its host/datapath.
// The host drives the master side; the sequencer implements the slave side.
interface aes_round_ctrl_param_if #(
  parameter int CNT_W = 4
) ();
  logic             start;
  logic [1:0]       key_len;
  logic             decrypt;
  logic             stall;
  logic             out_ready;
  logic             in_ready;
  logic             busy;
  logic             sel;
  logic             last_round;
  logic [CNT_W-1:0] round_cnt;
  logic [CNT_W-1:0] key_idx;
  logic             out_valid;
  logic             cfg_err;

  modport master (
    output start, key_len, decrypt, stall, out_ready,
    input  in_ready, busy, sel, last_round, round_cnt, key_idx, out_valid, cfg_err
  );

  modport slave (
    input  start, key_len, decrypt, stall, out_ready,
    output in_ready, busy, sel, last_round, round_cnt, key_idx, out_valid, cfg_err
  );
endinterface

// File: rtl/aes_round_ctrl_param.sv
// AES round sequencer for 10/12/14 rounds with encrypt/decrypt round-key ordering,
// start/ready intake, valid/ready result hold and a datapath stall.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | waiting for start; in_ready=1
//  S_INIT  | initial AddRoundKey, round_cnt=0, sel=0
//  S_ROUND | rounds 1..Nr-1, sel=1
//  S_FINAL | round Nr, MixColumns bypassed (last_round=1)
//  S_HOLD  | result valid, waiting for out_ready
module aes_round_ctrl_param #(
  parameter int CNT_W  = 4,
  parameter int NR_128 = 10,
  parameter int NR_192 = 12,
  parameter int NR_256 = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_round_ctrl_param_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nr_q, nr_d;
  logic             dec_q, dec_d;
  logic             cfg_err_q, cfg_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      nr_q      <= CNT_W'(NR_128);
      dec_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nr_q      <= nr_d;
      dec_q     <= dec_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nr_d      = nr_q;
    dec_d     = dec_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT;
          cnt_d   = '0;
          dec_d   = bus.decrypt;
          unique case (bus.key_len)
            2'b01:   nr_d = CNT_W'(NR_192);
            2'b10:   nr_d = CNT_W'(NR_256);
            default: nr_d = CNT_W'(NR_128);
          endcase
          cfg_err_d = (bus.key_len == 2'b11);
        end
      end
      S_INIT: begin
        if (!bus.stall) begin
          state_d = S_ROUND;
          cnt_d   = CNT_W'(1);
        end
      end
      S_ROUND: begin
        if (!bus.stall) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == nr_q - CNT_W'(1)) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (!bus.stall) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Every output is a decode of registered state; in_ready is the only one the host
  // may combine with start in the same cycle.
  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.sel        = (state_q == S_ROUND) || (state_q == S_FINAL) || (state_q == S_HOLD);
  assign bus.last_round = (state_q == S_FINAL);
  assign bus.out_valid  = (state_q == S_HOLD);
  assign bus.round_cnt  = cnt_q;
  assign bus.key_idx    = dec_q ? (nr_q - cnt_q) : cnt_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_aes_round_ctrl_param.sv
// Self-checking bench for aes_round_ctrl_param: directed scenarios plus randomized blocks,
// each checked cycle by cycle against a round-schedule model derived from Nr and the stall pattern.
module tb_aes_round_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  aes_round_ctrl_param_if #(.CNT_W(4)) bus ();

  aes_round_ctrl_param #(
    .CNT_W(4), .NR_128(10), .NR_192(12), .NR_256(14)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int nr_of(input logic [1:0] kl);
    return (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
  endfunction

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.key_len   = 2'b00;
    bus.decrypt   = 1'b0;
    bus.stall     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start     = 1'(($urandom));
      bus.key_len   = 2'($urandom);
      bus.decrypt   = 1'($urandom);
      bus.stall     = 1'($urandom);
      bus.out_ready = 1'($urandom);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.sel, bus.last_round, bus.out_valid, bus.cfg_err} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_flags got=%b want=100000",
               {bus.in_ready, bus.busy, bus.sel, bus.last_round, bus.out_valid, bus.cfg_err});
    end
    n_cmp++;
    if (bus.round_cnt !== 4'd0 || bus.key_idx !== 4'd0) begin
      n_err++;
      $display("FAIL reset_counts got cnt=%0d idx=%0d want 0/0", bus.round_cnt, bus.key_idx);
    end
    drive_idle();
    rst = 1'b0;
  endtask

  // Runs one block. stall_mode: 0 none, 1 window of stall_len cycles at round stall_at, 2 random.
  task automatic run_block(input logic [1:0] kl, input logic dec, input int stall_mode,
                           input int stall_at, input int stall_len, input int ready_wait,
                           input logic hold_start, input string tag);
    int   nr, step, cyc, stalls, hold_n, exp_cnt;
    logic done, hold, s;
    nr = nr_of(kl);
    step = 0; cyc = 0; stalls = 0; hold_n = 0; done = 1'b0;

    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_in_ready got=%b want=1", tag, bus.in_ready);
    end
    bus.start     = 1'b1;
    bus.key_len   = kl;
    bus.decrypt   = dec;
    bus.stall     = 1'($urandom);
    bus.out_ready = 1'($urandom);

    while (!done && cyc < 400) begin
      @(negedge clk);
      hold    = (step == nr + 1);
      exp_cnt = hold ? nr : step;
      n_cmp++;
      if ({bus.in_ready, bus.busy, bus.out_valid, bus.last_round} !== {1'b0, 1'b1, hold, (step == nr)}) begin
        n_err++;
        $display("FAIL %s flags cyc=%0d got ir/busy/ov/lr=%b want=%b", tag, cyc,
                 {bus.in_ready, bus.busy, bus.out_valid, bus.last_round},
                 {1'b0, 1'b1, hold, (step == nr)});
      end
      n_cmp++;
      if (bus.round_cnt !== 4'(exp_cnt)) begin
        n_err++;
        $display("FAIL %s round_cnt cyc=%0d got=%0d want=%0d", tag, cyc, bus.round_cnt, exp_cnt);
      end
      n_cmp++;
      if (bus.key_idx !== 4'(dec ? nr - exp_cnt : exp_cnt)) begin
        n_err++;
        $display("FAIL %s key_idx cyc=%0d got=%0d want=%0d", tag, cyc, bus.key_idx,
                 dec ? nr - exp_cnt : exp_cnt);
      end
      n_cmp++;
      if (bus.cfg_err !== ((cyc == 0) && (kl == 2'b11))) begin
        n_err++;
        $display("FAIL %s cfg_err cyc=%0d got=%b want=%b", tag, cyc, bus.cfg_err,
                 (cyc == 0) && (kl == 2'b11));
      end
      if (!hold) begin
        n_cmp++;
        if (bus.sel !== (step != 0)) begin
          n_err++;
          $display("FAIL %s sel cyc=%0d got=%b want=%b", tag, cyc, bus.sel, step != 0);
        end
      end

      case (stall_mode)
        1:       s = (step == stall_at) && (stalls < stall_len);
        2:       s = ($urandom_range(0, 99) < 30);
        default: s = 1'b0;
      endcase
      bus.stall     = s;
      bus.start     = hold ? hold_start : 1'($urandom);
      bus.key_len   = 2'($urandom);
      bus.decrypt   = 1'($urandom);
      bus.out_ready = hold ? (hold_n >= ready_wait) : 1'($urandom);

      if (!hold) begin
        if (s) stalls++;
        else   step++;
      end else begin
        if (bus.out_ready) done = 1'b1;
        hold_n++;
      end
      cyc++;
    end

    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout got=no_completion want=completion", tag);
    end

    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.last_round} !== 4'b1000 || bus.round_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL %s back_to_idle got ir/busy/ov/lr=%b cnt=%0d want=1000 cnt=0", tag,
               {bus.in_ready, bus.busy, bus.out_valid, bus.last_round}, bus.round_cnt);
    end
    drive_idle();
  endtask

  task automatic test_enc128();      run_block(2'b00, 1'b0, 0, 0, 0, 0, 1'b0, "enc128");    endtask
  task automatic test_dec256();      run_block(2'b10, 1'b1, 0, 0, 0, 0, 1'b0, "dec256");    endtask
  task automatic test_stall192();    run_block(2'b01, 1'b0, 1, 5, 3, 0, 1'b0, "stall192");  endtask
  task automatic test_backpressure(); run_block(2'b00, 1'b1, 0, 0, 0, 5, 1'b1, "backpress"); endtask
  task automatic test_cfg_err();     run_block(2'b11, 1'b0, 0, 0, 0, 0, 1'b0, "cfg_err");   endtask

  task automatic test_reset_mid();
    int ov_seen;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = 2'b10;
    bus.decrypt = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    n_cmp++;
    if (bus.round_cnt !== 4'd6 || bus.key_idx !== 4'd8) begin
      n_err++;
      $display("FAIL rst_mid pre got cnt=%0d idx=%0d want 6/8", bus.round_cnt, bus.key_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.sel, bus.last_round, bus.out_valid, bus.cfg_err} !== 6'b100000
        || bus.round_cnt !== 4'd0 || bus.key_idx !== 4'd0) begin
      n_err++;
      $display("FAIL rst_mid post got flags=%b cnt=%0d idx=%0d want 100000 0 0",
               {bus.in_ready, bus.busy, bus.sel, bus.last_round, bus.out_valid, bus.cfg_err},
               bus.round_cnt, bus.key_idx);
    end
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) ov_seen++;
    end
    n_cmp++;
    if (ov_seen != 0) begin
      n_err++;
      $display("FAIL rst_mid no_valid got=%0d active cycles want=0", ov_seen);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 20; b++) begin
      run_block(2'($urandom), 1'($urandom), 2, 0, 0, $urandom_range(0, 4),
                1'($urandom), "random");
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_enc128();
    test_dec256();
    test_stall192();
    test_backpressure();
    test_reset_mid();
    test_cfg_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
